// File: rtl/tuner_ctrl_if.sv
// Handshake bundles between tuner_ctrl (consumer) and tuner_phy (producer):
// one for the peak search, one for lock / interrupt / resume.
interface tuner_search_if #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 8
);
  localparam int CNT_W = $clog2(NUM_TARGET) + 1;

  logic                                 trig_val;
  logic                                 trig_rdy;
  logic                                 peaks_val;
  logic                                 peaks_rdy;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] ring_tune_peaks;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_peaks;
  logic [CNT_W-1:0]                     peaks_cnt;

  modport consumer (
    output trig_val, peaks_rdy,
    input  trig_rdy, peaks_val, ring_tune_peaks, pwr_peaks, peaks_cnt
  );
  modport producer (
    input  trig_val, peaks_rdy,
    output trig_rdy, peaks_val, ring_tune_peaks, pwr_peaks, peaks_cnt
  );
endinterface

interface tuner_lock_if;
  logic trig_val;
  logic trig_rdy;
  logic intr_val;
  logic intr_rdy;
  logic resume_val;
  logic resume_rdy;

  modport consumer (
    output trig_val, intr_rdy, resume_val,
    input  trig_rdy, intr_val, resume_rdy
  );
  modport producer (
    input  trig_val, intr_rdy, resume_val,
    output trig_rdy, intr_val, resume_rdy
  );
endinterface

// File: rtl/tuner_ctrl.sv
// Sequencer for one microring tuner: sweep, pick a peak, program it, lock,
// then service lock interrupts with bounded auto-relock.
module tuner_ctrl #(
  parameter int DAC_WIDTH     = 8,
  parameter int ADC_WIDTH     = 8,
  parameter int NUM_TARGET    = 8,
  parameter int MAX_RELOCK    = 3,
  parameter int STABLE_CYCLES = 1024
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_sel_mode,
  input  logic [$clog2(NUM_TARGET)-1:0] i_sel_idx,
  tuner_search_if.consumer              search_if,
  tuner_lock_if.consumer                lock_if,
  output logic [DAC_WIDTH-1:0]          o_cfg_ring_tune_peak,
  output logic [ADC_WIDTH-1:0]          o_cfg_pwr_peak,
  output logic                          o_busy,
  output logic                          o_locked,
  output logic                          o_err,
  output logic [1:0]                    o_err_code,
  output logic [15:0]                   o_intr_total,
  output logic [2:0]                    o_state
);
  localparam int IDX_W = $clog2(NUM_TARGET);
  localparam int CNT_W = IDX_W + 1;
  localparam int STB_W = $clog2(STABLE_CYCLES + 1);
  localparam int REL_W = $clog2(MAX_RELOCK + 2);

  typedef enum logic [2:0] {
    ST_IDLE, ST_S_TRIG, ST_S_WAIT, ST_SELECT, ST_L_TRIG, ST_LOCKED, ST_RESUME, ST_ERR
  } state_t;

  state_t                               state_q, state_d;
  logic                                 s_trig_val_q, s_trig_val_d;
  logic                                 peaks_rdy_q, peaks_rdy_d;
  logic                                 l_trig_val_q, l_trig_val_d;
  logic                                 intr_rdy_q, intr_rdy_d;
  logic                                 resume_val_q, resume_val_d;
  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] tune_q, tune_d;
  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] pwr_q, pwr_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic                                 sel_mode_q, sel_mode_d;
  logic [IDX_W-1:0]                     sel_idx_q, sel_idx_d;
  logic [IDX_W-1:0]                     scan_q, scan_d;
  logic [IDX_W-1:0]                     best_idx_q, best_idx_d;
  logic [ADC_WIDTH-1:0]                 best_pwr_q, best_pwr_d;
  logic [DAC_WIDTH-1:0]                 cfg_tune_q, cfg_tune_d;
  logic [ADC_WIDTH-1:0]                 cfg_pwr_q, cfg_pwr_d;
  logic [1:0]                           err_code_q, err_code_d;
  logic [15:0]                          intr_total_q, intr_total_d;
  logic [STB_W-1:0]                     stable_q, stable_d;
  logic [REL_W-1:0]                     relock_q, relock_d;
  logic                                 busy_q, busy_d;
  logic                                 locked_q, locked_d;
  logic                                 err_q, err_d;

  logic             s_trig_xfer, peaks_xfer, l_trig_xfer, intr_xfer, resume_xfer;
  logic [IDX_W-1:0] win_idx;
  logic [ADC_WIDTH-1:0] win_pwr;
  logic [REL_W-1:0] relock_nxt;

  assign s_trig_xfer = s_trig_val_q & search_if.trig_rdy;
  assign peaks_xfer  = peaks_rdy_q & search_if.peaks_val;
  assign l_trig_xfer = l_trig_val_q & lock_if.trig_rdy;
  assign intr_xfer   = intr_rdy_q & lock_if.intr_val;
  assign resume_xfer = resume_val_q & lock_if.resume_rdy;

  always_comb begin
    state_d      = state_q;
    tune_d       = tune_q;
    pwr_d        = pwr_q;
    cnt_d        = cnt_q;
    sel_mode_d   = sel_mode_q;
    sel_idx_d    = sel_idx_q;
    scan_d       = scan_q;
    best_idx_d   = best_idx_q;
    best_pwr_d   = best_pwr_q;
    cfg_tune_d   = cfg_tune_q;
    cfg_pwr_d    = cfg_pwr_q;
    err_code_d   = err_code_q;
    intr_total_d = intr_total_q;
    stable_d     = stable_q;
    relock_d     = relock_q;
    win_idx      = best_idx_q;
    win_pwr      = best_pwr_q;
    relock_nxt   = relock_q + REL_W'(1);

    unique case (state_q)
      ST_IDLE: if (i_start) state_d = ST_S_TRIG;
      ST_S_TRIG: if (s_trig_xfer) state_d = ST_S_WAIT;
      ST_S_WAIT: if (peaks_xfer) begin
        tune_d     = search_if.ring_tune_peaks;
        pwr_d      = search_if.pwr_peaks;
        cnt_d      = (search_if.peaks_cnt > CNT_W'(NUM_TARGET)) ? CNT_W'(NUM_TARGET)
                                                                : search_if.peaks_cnt;
        sel_mode_d = i_sel_mode;
        sel_idx_d  = i_sel_idx;
        scan_d     = '0;
        state_d    = ST_SELECT;
      end
      ST_SELECT: begin
        if (cnt_q == '0) begin
          err_code_d = 2'd1;
          state_d    = ST_ERR;
        end else if (!sel_mode_q) begin
          if ({1'b0, sel_idx_q} >= cnt_q) begin
            err_code_d = 2'd2;
            state_d    = ST_ERR;
          end else begin
            cfg_tune_d = tune_q[sel_idx_q];
            cfg_pwr_d  = pwr_q[sel_idx_q];
            state_d    = ST_L_TRIG;
          end
        end else begin
          // Strict '>' keeps the earliest entry on ties.
          if (scan_q == '0 || pwr_q[scan_q] > best_pwr_q) begin
            win_idx = scan_q;
            win_pwr = pwr_q[scan_q];
          end
          best_idx_d = win_idx;
          best_pwr_d = win_pwr;
          if ({1'b0, scan_q} == cnt_q - CNT_W'(1)) begin
            cfg_tune_d = tune_q[win_idx];
            cfg_pwr_d  = win_pwr;
            state_d    = ST_L_TRIG;
          end else begin
            scan_d = scan_q + IDX_W'(1);
          end
        end
      end
      ST_L_TRIG: if (l_trig_xfer) begin
        stable_d = '0;
        relock_d = '0;
        state_d  = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (intr_xfer) begin
          if (intr_total_q != '1) intr_total_d = intr_total_q + 16'd1;
          stable_d = '0;
          relock_d = relock_nxt;
          if (relock_nxt > REL_W'(MAX_RELOCK)) begin
            err_code_d = 2'd3;
            state_d    = ST_ERR;
          end else begin
            state_d = ST_RESUME;
          end
        end else if (stable_q == STB_W'(STABLE_CYCLES - 1)) begin
          stable_d = '0;
          relock_d = '0;
        end else begin
          stable_d = stable_q + STB_W'(1);
        end
      end
      ST_RESUME: if (resume_xfer) state_d = ST_LOCKED;
      ST_ERR: state_d = ST_ERR;
    endcase

    // Handshake and status outputs are registered decodes of the next state.
    s_trig_val_d = (state_d == ST_S_TRIG);
    peaks_rdy_d  = (state_d == ST_S_WAIT);
    l_trig_val_d = (state_d == ST_L_TRIG);
    intr_rdy_d   = (state_d == ST_LOCKED);
    resume_val_d = (state_d == ST_RESUME);
    locked_d     = (state_d == ST_LOCKED);
    err_d        = (state_d == ST_ERR);
    busy_d       = !(state_d == ST_IDLE || state_d == ST_LOCKED || state_d == ST_ERR);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      s_trig_val_q <= 1'b0;
      peaks_rdy_q  <= 1'b0;
      l_trig_val_q <= 1'b0;
      intr_rdy_q   <= 1'b0;
      resume_val_q <= 1'b0;
      tune_q       <= '0;
      pwr_q        <= '0;
      cnt_q        <= '0;
      sel_mode_q   <= 1'b0;
      sel_idx_q    <= '0;
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_pwr_q   <= '0;
      cfg_tune_q   <= '0;
      cfg_pwr_q    <= '0;
      err_code_q   <= '0;
      intr_total_q <= '0;
      stable_q     <= '0;
      relock_q     <= '0;
      busy_q       <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_trig_val_q <= s_trig_val_d;
      peaks_rdy_q  <= peaks_rdy_d;
      l_trig_val_q <= l_trig_val_d;
      intr_rdy_q   <= intr_rdy_d;
      resume_val_q <= resume_val_d;
      tune_q       <= tune_d;
      pwr_q        <= pwr_d;
      cnt_q        <= cnt_d;
      sel_mode_q   <= sel_mode_d;
      sel_idx_q    <= sel_idx_d;
      scan_q       <= scan_d;
      best_idx_q   <= best_idx_d;
      best_pwr_q   <= best_pwr_d;
      cfg_tune_q   <= cfg_tune_d;
      cfg_pwr_q    <= cfg_pwr_d;
      err_code_q   <= err_code_d;
      intr_total_q <= intr_total_d;
      stable_q     <= stable_d;
      relock_q     <= relock_d;
      busy_q       <= busy_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign search_if.trig_val   = s_trig_val_q;
  assign search_if.peaks_rdy  = peaks_rdy_q;
  assign lock_if.trig_val     = l_trig_val_q;
  assign lock_if.intr_rdy     = intr_rdy_q;
  assign lock_if.resume_val   = resume_val_q;
  assign o_cfg_ring_tune_peak = cfg_tune_q;
  assign o_cfg_pwr_peak       = cfg_pwr_q;
  assign o_busy               = busy_q;
  assign o_locked             = locked_q;
  assign o_err                = err_q;
  assign o_err_code           = err_code_q;
  assign o_intr_total         = intr_total_q;
  assign o_state              = state_q;
endmodule

// File: tb/tb_tuner_ctrl.sv
// Directed bench for tuner_ctrl: table of peak lists with expected selections,
// plus handshake-stall, relock and mid-operation reset sequences.
module tb_tuner_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, sel_mode;
  logic [2:0]  sel_idx;
  logic [7:0]  cfg_tune, cfg_pwr;
  logic        busy, locked, err;
  logic [1:0]  err_code;
  logic [15:0] intr_total;
  logic [2:0]  state;

  tuner_search_if s_if ();
  tuner_lock_if   l_if ();

  tuner_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sel_mode(sel_mode), .i_sel_idx(sel_idx),
    .search_if(s_if), .lock_if(l_if),
    .o_cfg_ring_tune_peak(cfg_tune), .o_cfg_pwr_peak(cfg_pwr), .o_busy(busy),
    .o_locked(locked), .o_err(err), .o_err_code(err_code), .o_intr_total(intr_total),
    .o_state(state)
  );

  typedef struct {
    logic [3:0]      cnt;
    logic [7:0][7:0] pwr;
    logic [7:0][7:0] tune;
    logic            mode;
    logic [2:0]      idx;
    logic            exp_err;
    logic [1:0]      exp_code;
    logic [7:0]      exp_tune;
    logic [7:0]      exp_pwr;
    int              exp_sel;
  } vec_t;

  int n_err = 0;
  int n_chk = 0;

  // Monotonic event counters sampled on the falling edge.
  int n_strig_x = 0, n_strig_hi = 0, n_peaks_x = 0, n_ltrig_x = 0, n_ltrig_hi = 0;
  int n_intr_x = 0, n_res_x = 0, n_res_hi = 0, n_sel = 0;
  always @(negedge clk) begin
    if (s_if.trig_val && s_if.trig_rdy) n_strig_x <= n_strig_x + 1;
    if (s_if.trig_val) n_strig_hi <= n_strig_hi + 1;
    if (s_if.peaks_rdy && s_if.peaks_val) n_peaks_x <= n_peaks_x + 1;
    if (l_if.trig_val && l_if.trig_rdy) n_ltrig_x <= n_ltrig_x + 1;
    if (l_if.trig_val) n_ltrig_hi <= n_ltrig_hi + 1;
    if (l_if.intr_rdy && l_if.intr_val) n_intr_x <= n_intr_x + 1;
    if (l_if.resume_val && l_if.resume_rdy) n_res_x <= n_res_x + 1;
    if (l_if.resume_val) n_res_hi <= n_res_hi + 1;
    if (state == 3'd3) n_sel <= n_sel + 1;
  end

  function automatic logic [63:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic vec_t mk(input int cnt, input logic [63:0] pwr, input logic [63:0] tune,
                              input int mode, input int idx, input int e, input int code,
                              input int et, input int ep, input int sel);
    vec_t v;
    v.cnt = 4'(cnt); v.pwr = pwr; v.tune = tune; v.mode = 1'(mode); v.idx = 3'(idx);
    v.exp_err = 1'(e); v.exp_code = 2'(code); v.exp_tune = 8'(et); v.exp_pwr = 8'(ep);
    v.exp_sel = sel;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input vec_t v);
    s_if.peaks_cnt       = v.cnt;
    s_if.pwr_peaks       = v.pwr;
    s_if.ring_tune_peaks = v.tune;
    sel_mode             = v.mode;
    sel_idx              = v.idx;
    s_if.peaks_val       = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (locked || err) begin ok = 1'b1; break; end
    end
    #1;
    check({nm, "_done"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_state(input string nm, input logic [2:0] st);
    bit ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (state == st) begin ok = 1'b1; break; end
    end
    #1;
    check({nm, "_state"}, 32'(ok), 32'd1);
  endtask

  task automatic fire_intr(input string nm);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    l_if.intr_val = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (l_if.intr_rdy) begin ok = 1'b1; break; end
    end
    @(posedge clk);
    #1;
    l_if.intr_val = 1'b0;
    check({nm, "_intr_taken"}, 32'(ok), 32'd1);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_ctl"}, 32'({busy, locked, err, err_code, state, s_if.trig_val, s_if.peaks_rdy,
                             l_if.trig_val, l_if.intr_rdy, l_if.resume_val}), 32'd0);
    check({nm, "_cfg"}, 32'({cfg_tune, cfg_pwr}), 32'd0);
    check({nm, "_total"}, 32'(intr_total), 32'd0);
  endtask

  vec_t vecs[10];
  vec_t t1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int b_strig_x, b_strig_hi, b_peaks, b_ltrig_x, b_ltrig_hi, b_sel, b_res_x, b_res_hi, b_intr;

    t1 = mk(3, pack8(40, 90, 60, 0, 0, 0, 0, 0), pack8(10, 50, 80, 0, 0, 0, 0, 0),
            1, 0, 0, 0, 50, 90, 3);
    vecs[0] = t1;
    vecs[1] = mk(2, pack8(40, 90, 0, 0, 0, 0, 0, 0), pack8(10, 50, 0, 0, 0, 0, 0, 0),
                 0, 2, 1, 2, 0, 0, 1);
    vecs[2] = mk(0, pack8(5, 6, 7, 0, 0, 0, 0, 0), pack8(1, 2, 3, 0, 0, 0, 0, 0),
                 1, 0, 1, 1, 0, 0, 1);
    vecs[3] = mk(2, pack8(70, 70, 0, 0, 0, 0, 0, 0), pack8(5, 6, 0, 0, 0, 0, 0, 0),
                 1, 0, 0, 0, 5, 70, 2);
    vecs[4] = mk(3, pack8(40, 90, 60, 0, 0, 0, 0, 0), pack8(10, 50, 80, 0, 0, 0, 0, 0),
                 0, 1, 0, 0, 50, 90, 1);
    vecs[5] = mk(8, pack8(1, 2, 3, 200, 4, 200, 5, 6), pack8(11, 12, 13, 14, 15, 16, 17, 18),
                 1, 0, 0, 0, 14, 200, 8);
    vecs[6] = mk(15, pack8(9, 8, 7, 6, 5, 4, 3, 250), pack8(1, 2, 3, 4, 5, 6, 7, 8),
                 1, 0, 0, 0, 8, 250, 8);
    vecs[7] = mk(4, pack8(10, 20, 30, 40, 0, 0, 0, 0), pack8(100, 101, 102, 103, 0, 0, 0, 0),
                 1, 0, 0, 0, 103, 40, 4);
    vecs[8] = mk(12, pack8(1, 1, 1, 1, 1, 1, 1, 77), pack8(2, 2, 2, 2, 2, 2, 2, 33),
                 0, 7, 0, 0, 33, 77, 1);
    vecs[9] = mk(1, pack8(50, 60, 0, 0, 0, 0, 0, 0), pack8(3, 4, 0, 0, 0, 0, 0, 0),
                 0, 1, 1, 2, 0, 0, 1);

    s_if.trig_rdy = 1'b1;
    s_if.peaks_val = 1'b0;
    s_if.peaks_cnt = '0;
    s_if.pwr_peaks = '0;
    s_if.ring_tune_peaks = '0;
    l_if.trig_rdy = 1'b1;
    l_if.intr_val = 1'b0;
    l_if.resume_rdy = 1'b1;
    sel_mode = 1'b0;
    sel_idx = '0;
    start = 1'b0;
    rst = 1'b1;

    do_reset();
    @(negedge clk);
    #1;
    check_zero("reset");

    // Table of peak lists
    for (int i = 0; i < 10; i++) begin
      do_reset();
      load(vecs[i]);
      b_strig_x = n_strig_x; b_peaks = n_peaks_x; b_ltrig_x = n_ltrig_x;
      b_ltrig_hi = n_ltrig_hi; b_sel = n_sel;
      pulse_start();
      wait_done($sformatf("v%0d", i));
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_code", i), 32'(err_code), 32'(vecs[i].exp_code));
      check($sformatf("v%0d_sel_cycles", i), 32'(n_sel - b_sel), 32'(vecs[i].exp_sel));
      check($sformatf("v%0d_strig_xfers", i), 32'(n_strig_x - b_strig_x), 32'd1);
      check($sformatf("v%0d_peaks_xfers", i), 32'(n_peaks_x - b_peaks), 32'd1);
      if (vecs[i].exp_err) begin
        check($sformatf("v%0d_ltrig_high", i), 32'(n_ltrig_hi - b_ltrig_hi), 32'd0);
        check($sformatf("v%0d_locked", i), 32'(locked), 32'd0);
      end else begin
        check($sformatf("v%0d_tune", i), 32'(cfg_tune), 32'(vecs[i].exp_tune));
        check($sformatf("v%0d_pwr", i), 32'(cfg_pwr), 32'(vecs[i].exp_pwr));
        check($sformatf("v%0d_locked", i), 32'(locked), 32'd1);
        check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        check($sformatf("v%0d_ltrig_xfers", i), 32'(n_ltrig_x - b_ltrig_x), 32'd1);
      end
    end

    // Search trigger stalled for 5 cycles
    do_reset();
    load(t1);
    s_if.trig_rdy = 1'b0;
    b_strig_x = n_strig_x; b_strig_hi = n_strig_hi;
    pulse_start();
    repeat (5) tick();
    check("strig_stall_high", 32'(n_strig_hi - b_strig_hi), 32'd5);
    check("strig_stall_noxfer", 32'(n_strig_x - b_strig_x), 32'd0);
    s_if.trig_rdy = 1'b1;
    wait_done("strig_stall");
    check("strig_stall_xfers", 32'(n_strig_x - b_strig_x), 32'd1);
    check("strig_stall_high_total", 32'(n_strig_hi - b_strig_hi), 32'd6);
    check("strig_stall_locked", 32'(locked), 32'd1);

    // Resume stalled for 5 cycles
    l_if.resume_rdy = 1'b0;
    b_res_x = n_res_x; b_res_hi = n_res_hi;
    fire_intr("res_stall");
    repeat (5) tick();
    check("res_stall_high", 32'(n_res_hi - b_res_hi), 32'd5);
    check("res_stall_noxfer", 32'(n_res_x - b_res_x), 32'd0);
    l_if.resume_rdy = 1'b1;
    wait_state("res_stall", 3'd5);
    repeat (3) tick();
    check("res_stall_xfers", 32'(n_res_x - b_res_x), 32'd1);
    check("res_stall_high_total", 32'(n_res_hi - b_res_hi), 32'd6);
    check("res_stall_total", 32'(intr_total), 32'd1);

    // Back-to-back interrupts exhaust the relock budget
    do_reset();
    load(t1);
    pulse_start();
    wait_done("b2b");
    b_res_x = n_res_x; b_intr = n_intr_x;
    for (int k = 0; k < 4; k++) fire_intr($sformatf("b2b%0d", k));
    @(negedge clk);
    #1;
    check("b2b_err", 32'(err), 32'd1);
    check("b2b_code", 32'(err_code), 32'd3);
    check("b2b_total", 32'(intr_total), 32'd4);
    check("b2b_resumes", 32'(n_res_x - b_res_x), 32'd3);
    check("b2b_intrs", 32'(n_intr_x - b_intr), 32'd4);
    check("b2b_err_quiet", 32'({l_if.trig_val, l_if.intr_rdy, l_if.resume_val,
                                s_if.trig_val, s_if.peaks_rdy}), 32'd0);
    pulse_start();
    check("b2b_err_sticky", 32'(state), 32'd7);

    // A stable interval before the fourth interrupt clears the budget
    do_reset();
    load(t1);
    pulse_start();
    wait_done("gap");
    b_res_x = n_res_x;
    for (int k = 0; k < 3; k++) fire_intr($sformatf("gap%0d", k));
    wait_state("gap_locked", 3'd5);
    repeat (1030) tick();
    fire_intr("gap3");
    wait_state("gap_relocked", 3'd5);
    check("gap_err", 32'(err), 32'd0);
    check("gap_resumes", 32'(n_res_x - b_res_x), 32'd4);
    check("gap_total", 32'(intr_total), 32'd4);

    // Reset while waiting for peaks
    do_reset();
    load(t1);
    s_if.peaks_val = 1'b0;
    pulse_start();
    wait_state("rst_wait", 3'd2);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("rst_wait");
    rst = 1'b0;
    load(t1);
    pulse_start();
    wait_done("rst_wait_rerun");
    check("rst_wait_rerun_tune", 32'(cfg_tune), 32'd50);
    check("rst_wait_rerun_pwr", 32'(cfg_pwr), 32'd90);
    check("rst_wait_rerun_locked", 32'(locked), 32'd1);

    // Reset during resume
    l_if.resume_rdy = 1'b0;
    fire_intr("rst_res");
    wait_state("rst_res", 3'd6);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("rst_res");
    rst = 1'b0;
    l_if.resume_rdy = 1'b1;
    b_ltrig_x = n_ltrig_x;
    load(t1);
    pulse_start();
    wait_done("rst_res_rerun");
    check("rst_res_rerun_tune", 32'(cfg_tune), 32'd50);
    check("rst_res_rerun_pwr", 32'(cfg_pwr), 32'd90);
    check("rst_res_rerun_locked", 32'(locked), 32'd1);
    check("rst_res_rerun_ltrig", 32'(n_ltrig_x - b_ltrig_x), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
